// File: rtl/de_pipe_reg.sv
// D/E pipeline register: captures the decoded bundle for E, raises the MDU hazard
// stall, and turns stall/flush cycles into bubbles that keep EPC information intact.
module de_pipe_reg #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
    parameter int          DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall_other,
    input  logic          md_busy,
    input  logic [DW-1:0] d_instr,
    input  logic [31:0]   d_pc,
    input  logic [DW-1:0] d_rs,
    input  logic [DW-1:0] d_rt,
    input  logic [DW-1:0] d_imm,
    input  logic [4:0]    d_wa,
    input  logic [3:0]    d_mdu_op,
    input  logic [4:0]    d_exc,
    input  logic          d_bd,
    output logic [DW-1:0] e_instr,
    output logic [31:0]   e_pc,
    output logic [DW-1:0] e_rs,
    output logic [DW-1:0] e_rt,
    output logic [DW-1:0] e_imm,
    output logic [4:0]    e_wa,
    output logic [3:0]    e_mdu_op,
    output logic          e_mdu_start,
    output logic [4:0]    e_exc,
    output logic          e_bd,
    output logic          stall
);

    logic [DW-1:0] e_instr_q, e_instr_d;
    logic [31:0]   e_pc_q, e_pc_d;
    logic [DW-1:0] e_rs_q, e_rs_d;
    logic [DW-1:0] e_rt_q, e_rt_d;
    logic [DW-1:0] e_imm_q, e_imm_d;
    logic [4:0]    e_wa_q, e_wa_d;
    logic [3:0]    e_mdu_op_q, e_mdu_op_d;
    logic          e_mdu_start_q, e_mdu_start_d;
    logic [4:0]    e_exc_q, e_exc_d;
    logic          e_bd_q, e_bd_d;

    logic d_uses_mdu;
    logic d_starts_mdu;
    logic stall_md;

    assign d_uses_mdu   = (d_mdu_op != 4'd0) && (d_mdu_op <= 4'd8);
    assign d_starts_mdu = (d_mdu_op != 4'd0) && (d_mdu_op <= 4'd4);

    // e_mdu_start covers the cycle before the MDU raises Busy.
    assign stall_md = d_uses_mdu && (md_busy || e_mdu_start_q);
    assign stall    = stall_other || stall_md;

    always_comb begin
        e_instr_d     = '0;
        e_pc_d        = d_pc;
        e_rs_d        = '0;
        e_rt_d        = '0;
        e_imm_d       = '0;
        e_wa_d        = '0;
        e_mdu_op_d    = '0;
        e_mdu_start_d = 1'b0;
        e_exc_d       = '0;
        e_bd_d        = d_bd;

        if (req) begin
            e_pc_d = PC_HANDLER;
            e_bd_d = 1'b0;
        end else if (!stall) begin
            e_instr_d     = d_instr;
            e_rs_d        = d_rs;
            e_rt_d        = d_rt;
            e_imm_d       = d_imm;
            e_wa_d        = d_wa;
            e_mdu_op_d    = d_mdu_op;
            e_mdu_start_d = d_starts_mdu;
            e_exc_d       = d_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_instr_q     <= '0;
            e_pc_q        <= PC_RESET;
            e_rs_q        <= '0;
            e_rt_q        <= '0;
            e_imm_q       <= '0;
            e_wa_q        <= '0;
            e_mdu_op_q    <= '0;
            e_mdu_start_q <= 1'b0;
            e_exc_q       <= '0;
            e_bd_q        <= 1'b0;
        end else begin
            e_instr_q     <= e_instr_d;
            e_pc_q        <= e_pc_d;
            e_rs_q        <= e_rs_d;
            e_rt_q        <= e_rt_d;
            e_imm_q       <= e_imm_d;
            e_wa_q        <= e_wa_d;
            e_mdu_op_q    <= e_mdu_op_d;
            e_mdu_start_q <= e_mdu_start_d;
            e_exc_q       <= e_exc_d;
            e_bd_q        <= e_bd_d;
        end
    end

    assign e_instr     = e_instr_q;
    assign e_pc        = e_pc_q;
    assign e_rs        = e_rs_q;
    assign e_rt        = e_rt_q;
    assign e_imm       = e_imm_q;
    assign e_wa        = e_wa_q;
    assign e_mdu_op    = e_mdu_op_q;
    assign e_mdu_start = e_mdu_start_q;
    assign e_exc       = e_exc_q;
    assign e_bd        = e_bd_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed-vector bench for de_pipe_reg: hand-computed expectations for capture,
// MDU hazard stalls, bubbles, flushes and start-pulse counting.
module tb_de_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, req, stall_other, md_busy;
    logic [31:0] d_instr, d_pc, d_rs, d_rt, d_imm;
    logic [4:0]  d_wa;
    logic [3:0]  d_mdu_op;
    logic [4:0]  d_exc;
    logic        d_bd;
    logic [31:0] e_instr, e_pc, e_rs, e_rt, e_imm;
    logic [4:0]  e_wa;
    logic [3:0]  e_mdu_op;
    logic        e_mdu_start;
    logic [4:0]  e_exc;
    logic        e_bd, stall;

    int n_vec  = 0;
    int n_miss = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    de_pipe_reg dut (
        .clk(clk), .reset(reset), .req(req), .stall_other(stall_other),
        .md_busy(md_busy), .d_instr(d_instr), .d_pc(d_pc), .d_rs(d_rs),
        .d_rt(d_rt), .d_imm(d_imm), .d_wa(d_wa), .d_mdu_op(d_mdu_op),
        .d_exc(d_exc), .d_bd(d_bd), .e_instr(e_instr), .e_pc(e_pc),
        .e_rs(e_rs), .e_rt(e_rt), .e_imm(e_imm), .e_wa(e_wa),
        .e_mdu_op(e_mdu_op), .e_mdu_start(e_mdu_start), .e_exc(e_exc),
        .e_bd(e_bd), .stall(stall)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] op,
                         input logic [4:0] wa, input logic [4:0] exc, input logic bd);
        d_instr  = instr;
        d_pc     = pc;
        d_mdu_op = op;
        d_wa     = wa;
        d_exc    = exc;
        d_bd     = bd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; req = 0; stall_other = 0; md_busy = 0;
        d_rs = 0; d_rt = 0; d_imm = 0;
        set_d(32'h0, 32'h0, 4'd0, 5'd0, 5'd0, 1'b0);
        step(); step();
        check_vec("rst_pc",    e_pc, 32'h0000_3000);
        check_vec("rst_instr", e_instr, 32'h0);
        check_vec("rst_wa",    {27'b0, e_wa}, 32'h0);
        check_vec("rst_start", {31'b0, e_mdu_start}, 32'h0);
        check_vec("rst_bd",    {31'b0, e_bd}, 32'h0);
        check_vec("rst_stall", {31'b0, stall}, 32'h0);
        reset = 0;

        // mult with full capture
        set_d(32'h0064_0018, 32'h0000_3000, 4'd2, 5'd0, 5'd0, 1'b0);
        d_rs = 32'hFFFF_FFFE; d_rt = 32'h3; d_imm = 32'h1234;
        #1 check_vec("mult_nostall", {31'b0, stall}, 32'h0);
        step();
        check_vec("mult_op",    {28'b0, e_mdu_op}, 32'd2);
        check_vec("mult_start", {31'b0, e_mdu_start}, 32'h1);
        check_vec("mult_rs",    e_rs, 32'hFFFF_FFFE);
        check_vec("mult_rt",    e_rt, 32'h3);
        check_vec("mult_imm",   e_imm, 32'h1234);
        check_vec("mult_instr", e_instr, 32'h0064_0018);
        set_d(32'h0000_0000, 32'h0000_3004, 4'd0, 5'd8, 5'd0, 1'b0);
        #1 check_vec("nop_nostall", {31'b0, stall}, 32'h0);
        step();
        check_vec("nop_start", {31'b0, e_mdu_start}, 32'h0);
        check_vec("nop_wa",    {27'b0, e_wa}, 32'd8);
        check_vec("nop_pc",    e_pc, 32'h0000_3004);

        // mult then mflo
        set_d(32'h0064_0018, 32'h0000_3008, 4'd2, 5'd0, 5'd0, 1'b0);
        step();
        check_vec("mm_start", {31'b0, e_mdu_start}, 32'h1);
        set_d(32'h0000_4812, 32'h0000_300C, 4'd8, 5'd9, 5'd0, 1'b0);
        #1 check_vec("mm_stall_gap", {31'b0, stall}, 32'h1);
        step();
        check_vec("mm_bub_wa",    {27'b0, e_wa}, 32'h0);
        check_vec("mm_bub_pc",    e_pc, 32'h0000_300C);
        check_vec("mm_bub_start", {31'b0, e_mdu_start}, 32'h0);
        md_busy = 1;
        for (int i = 0; i < 5; i++) begin
            #1 check_vec("mm_busy_stall", {31'b0, stall}, 32'h1);
            step();
            check_vec("mm_busy_wa", {27'b0, e_wa}, 32'h0);
            check_vec("mm_busy_pc", e_pc, 32'h0000_300C);
        end
        md_busy = 0;
        #1 check_vec("mm_free", {31'b0, stall}, 32'h0);
        step();
        check_vec("mflo_op",    {28'b0, e_mdu_op}, 32'd8);
        check_vec("mflo_start", {31'b0, e_mdu_start}, 32'h0);
        check_vec("mflo_wa",    {27'b0, e_wa}, 32'd9);

        // non-MDU stall bubble, exception cleared
        set_d(32'h2345_0001, 32'h0000_3010, 4'd0, 5'd5, 5'd3, 1'b1);
        stall_other = 1;
        #1 check_vec("so_stall", {31'b0, stall}, 32'h1);
        step();
        check_vec("so_wa",    {27'b0, e_wa}, 32'h0);
        check_vec("so_start", {31'b0, e_mdu_start}, 32'h0);
        check_vec("so_pc",    e_pc, 32'h0000_3010);
        check_vec("so_bd",    {31'b0, e_bd}, 32'h1);
        check_vec("so_exc",   {27'b0, e_exc}, 32'h0);
        check_vec("so_instr", e_instr, 32'h0);

        // flush overrides stall
        set_d(32'h0064_001A, 32'h0000_3014, 4'd4, 5'd0, 5'd5, 1'b1);
        req = 1;
        step();
        check_vec("req_pc",    e_pc, 32'h0000_4180);
        check_vec("req_start", {31'b0, e_mdu_start}, 32'h0);
        check_vec("req_exc",   {27'b0, e_exc}, 32'h0);
        check_vec("req_bd",    {31'b0, e_bd}, 32'h0);
        check_vec("req_op",    {28'b0, e_mdu_op}, 32'h0);
        req = 0; stall_other = 0;

        // busy only matters for MDU ops
        md_busy = 1;
        set_d(32'h0, 32'h0000_3018, 4'd0, 5'd1, 5'd0, 1'b0);
        #1 check_vec("busy_op0", {31'b0, stall}, 32'h0);
        d_mdu_op = 4'd5;
        #1 check_vec("busy_mthi", {31'b0, stall}, 32'h1);
        md_busy = 0;
        #1 check_vec("free_mthi", {31'b0, stall}, 32'h0);

        // reset wins over stall
        stall_other = 1; reset = 1;
        set_d(32'h0, 32'h0000_3020, 4'd1, 5'd2, 5'd0, 1'b1);
        step();
        check_vec("rst_mid_pc", e_pc, 32'h0000_3000);
        check_vec("rst_mid_bd", {31'b0, e_bd}, 32'h0);
        reset = 0; stall_other = 0;

        // ten divu, each followed by a 10-cycle busy window
        for (int i = 0; i < 10; i++) begin
            set_d(32'h0064_001B, 32'h0000_3100 + 32'(4 * i), 4'd3, 5'd0, 5'd0, 1'b0);
            md_busy = 0;
            step();
            if (e_mdu_start) pulses++;
            check_vec("divu_issue", {31'b0, e_mdu_start}, 32'h1);
            #1 check_vec("divu_gap_stall", {31'b0, stall}, 32'h1);
            step();
            if (e_mdu_start) pulses++;
            check_vec("divu_gap_start", {31'b0, e_mdu_start}, 32'h0);
            md_busy = 1;
            for (int j = 0; j < 10; j++) begin
                #1 check_vec("divu_busy_stall", {31'b0, stall}, 32'h1);
                step();
                if (e_mdu_start) pulses++;
                check_vec("divu_busy_start", {31'b0, e_mdu_start}, 32'h0);
            end
        end
        md_busy = 0;
        check_vec("divu_pulses", 32'(pulses), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
